// File: rtl/flash_hps_bridge.sv
// flash_hps_bridge: connects HPS change/schedule/tick requests to the flash_rtl core
// over three independent 4-phase req/grant handshakes.
module flash_hps_bridge #(
    parameter int PID_W      = 16,
    parameter int PRI_W      = 8,
    parameter int TYPE_W     = 8,
    parameter int STATE_W    = 16,
    parameter int N_CPU      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [TYPE_W+PID_W+PRI_W+STATE_W-1:0]   hps_change_data,
    input  logic                                    hps_change_valid,
    output logic                                    hps_change_full,
    output logic [7:0]                              hps_change_drops,
    input  logic [N_CPU-1:0]                        hps_sched_req,
    output logic [N_CPU-1:0]                        hps_sched_done,
    output logic [PID_W-1:0]                        hps_next_process,
    output logic                                    hps_tick_irq,
    output logic                                    hps_tick_overrun,
    input  logic                                    hps_tick_ack,
    output logic                                    f_sched_req,
    input  logic                                    f_sched_grant,
    input  logic [PID_W-1:0]                        f_next_process,
    input  logic                                    f_tick_req,
    output logic                                    f_tick_grant,
    output logic                                    f_change_req,
    output logic [TYPE_W-1:0]                       f_change_type,
    output logic [PID_W-1:0]                        f_change_pid,
    output logic [PRI_W-1:0]                        f_change_pri,
    output logic [STATE_W-1:0]                      f_change_state,
    input  logic                                    f_change_grant
);
    localparam int CHG_W = TYPE_W + PID_W + PRI_W + STATE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = (N_CPU > 1) ? $clog2(N_CPU) : 1;

    localparam logic [1:0] C_IDLE = 2'd0, C_REQ = 2'd1, C_WAIT = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2;

    logic [CHG_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_drops;
    logic             w_full, w_empty, w_push, w_pop;

    logic [1:0]       r_cstate;
    logic             r_change_req;
    logic [CHG_W-1:0] r_change_data;

    logic [1:0]       r_sstate;
    logic             r_sched_req;
    logic [N_CPU-1:0] r_pending, r_done, w_clr;
    logic [CW-1:0]    r_rr, r_cur, w_sel;
    logic [CW:0]      w_idx;
    logic             w_found;
    logic [PID_W-1:0] r_next_pid;

    logic             r_tick_grant, r_irq, r_overrun;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign w_full  = (r_count == FIFO_DEPTH[AW:0]);
    assign w_empty = (r_count == '0);
    assign w_push  = hps_change_valid && !w_full;
    assign w_pop   = (r_cstate == C_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= hps_change_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drops  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (hps_change_valid && w_full && r_drops != 8'hFF) r_drops <= r_drops + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate      <= C_IDLE;
            r_change_req  <= 1'b0;
            r_change_data <= '0;
        end else begin
            case (r_cstate)
                C_IDLE: if (!w_empty) begin
                    r_change_data <= r_mem[r_rd_ptr];
                    r_change_req  <= 1'b1;
                    r_cstate      <= C_REQ;
                end
                C_REQ: if (f_change_grant) begin
                    r_change_req <= 1'b0;
                    r_cstate     <= C_WAIT;
                end
                C_WAIT: if (!f_change_grant) r_cstate <= C_IDLE;
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    // Round-robin pick: first pending channel at or after r_rr, wrapping.
    always_comb begin
        w_sel   = r_rr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_CPU; k++) begin
            w_idx = {1'b0, r_rr} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(N_CPU)) w_idx = w_idx - (CW+1)'(N_CPU);
            if (!w_found && r_pending[w_idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if (r_sstate == S_REQ && f_sched_grant) w_clr[r_cur] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sstate    <= S_IDLE;
            r_sched_req <= 1'b0;
            r_pending   <= '0;
            r_done      <= '0;
            r_rr        <= '0;
            r_cur       <= '0;
            r_next_pid  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | hps_sched_req;
            r_done    <= '0;
            case (r_sstate)
                S_IDLE: if (w_found) begin
                    r_cur       <= w_sel;
                    r_sched_req <= 1'b1;
                    r_sstate    <= S_REQ;
                end
                S_REQ: if (f_sched_grant) begin
                    r_next_pid    <= f_next_process;
                    r_sched_req   <= 1'b0;
                    r_done[r_cur] <= 1'b1;
                    r_rr          <= (r_cur == CW'(N_CPU - 1)) ? '0 : r_cur + 1'b1;
                    r_sstate      <= S_WAIT;
                end
                S_WAIT: if (!f_sched_grant) r_sstate <= S_IDLE;
                default: r_sstate <= S_IDLE;
            endcase
        end
    end

    // A new tick outranks a same-cycle ack: irq stays set and overrun is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_grant <= 1'b0;
            r_irq        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (f_tick_req && !r_tick_grant) begin
                r_tick_grant <= 1'b1;
                r_irq        <= 1'b1;
                if (hps_tick_ack)  r_overrun <= 1'b0;
                else if (r_irq)    r_overrun <= 1'b1;
            end else begin
                if (!f_tick_req && r_tick_grant) r_tick_grant <= 1'b0;
                if (hps_tick_ack) begin
                    r_irq     <= 1'b0;
                    r_overrun <= 1'b0;
                end
            end
        end
    end

    assign hps_change_full  = w_full;
    assign hps_change_drops = r_drops;
    assign f_change_req     = r_change_req;
    assign f_change_type    = r_change_data[TYPE_W-1:0];
    assign f_change_pid     = r_change_data[TYPE_W +: PID_W];
    assign f_change_pri     = r_change_data[TYPE_W+PID_W +: PRI_W];
    assign f_change_state   = r_change_data[TYPE_W+PID_W+PRI_W +: STATE_W];
    assign f_sched_req      = r_sched_req;
    assign hps_sched_done   = r_done;
    assign hps_next_process = r_next_pid;
    assign f_tick_grant     = r_tick_grant;
    assign hps_tick_irq     = r_irq;
    assign hps_tick_overrun = r_overrun;
endmodule
